// File: rtl/flash_seq_pkg.sv
// Shared types and default timing for the flash read sequencer.
// Phase lengths are in wb_clk_i cycles.
package flash_seq_pkg;
  localparam int FSEQ_PRE_CYC = 4;
  localparam int FSEQ_SEN_CYC = 8;
  localparam int FSEQ_OE_CYC  = 2;
  localparam int FSEQ_DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SENSE,
    ST_OUT,
    ST_RESP
  } fseq_state_t;
endpackage

// File: rtl/flash_out_sync.sv
// Two-flop synchronizer for the flash array output bus, which is
// asynchronous to the controller clock.
module flash_out_sync
  import flash_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FSEQ_DATA_W-1:0] d,
  output logic [FSEQ_DATA_W-1:0] q
);
  logic [FSEQ_DATA_W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/flash_read_sequencer.sv
// Read controller for flash_array_8x8: timed precharge/sense/output
// sequence on sen1/sen2/out_en, then captures the synchronized array data.
module flash_read_sequencer
  import flash_seq_pkg::*;
#(
  parameter int PRE_CYC = FSEQ_PRE_CYC,
  parameter int SEN_CYC = FSEQ_SEN_CYC,
  parameter int OE_CYC  = FSEQ_OE_CYC
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [3:0]             req_sel_i,
  input  logic                   abort_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [FSEQ_DATA_W-1:0] rsp_data_o,
  output logic                   rsp_err_o,
  output logic [15:0]            rd_count_o,
  output logic                   sen1_o,
  output logic                   sen2_o,
  output logic [3:0]             out_en_o,
  input  logic [FSEQ_DATA_W-1:0] flash_out_i
);
  // Counter reload values: phase length minus one.  OUT runs two extra
  // cycles so the synchronizer has flushed data driven under out_en.
  localparam logic [7:0] PRE_LD = 8'(PRE_CYC - 1);
  localparam logic [7:0] SEN_LD = 8'(SEN_CYC - 1);
  localparam logic [7:0] OUT_LD = 8'(OE_CYC + 1);

  fseq_state_t            state;
  logic [7:0]             cnt;
  logic [3:0]             sel_q;
  logic [FSEQ_DATA_W-1:0] sync_q;
  logic                   last;

  flash_out_sync u_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .d     (flash_out_i),
    .q     (sync_q)
  );

  assign last = (cnt == 8'd0);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sel_q       <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      rd_count_o  <= '0;
      sen1_o      <= 1'b0;
      sen2_o      <= 1'b0;
      out_en_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            sel_q       <= req_sel_i;
            req_ready_o <= 1'b0;
            if (req_sel_i == 4'd0) begin
              // Empty select: answer with an error, leave the array alone.
              state       <= ST_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_data_o  <= '0;
            end else begin
              state  <= ST_PRE;
              cnt    <= PRE_LD;
              sen1_o <= 1'b1;
            end
          end
        end
        ST_PRE, ST_SENSE, ST_OUT: begin
          if (abort_i) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            sen1_o      <= 1'b0;
            sen2_o      <= 1'b0;
            out_en_o    <= '0;
          end else if (!last) begin
            cnt <= cnt - 8'd1;
          end else if (state == ST_PRE) begin
            state  <= ST_SENSE;
            cnt    <= SEN_LD;
            sen2_o <= 1'b1;
          end else if (state == ST_SENSE) begin
            state    <= ST_OUT;
            cnt      <= OUT_LD;
            out_en_o <= sel_q;
          end else begin
            state       <= ST_RESP;
            sen1_o      <= 1'b0;
            sen2_o      <= 1'b0;
            out_en_o    <= '0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= sync_q;
            rd_count_o  <= rd_count_o + 16'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b0;
          sen1_o      <= 1'b0;
          sen2_o      <= 1'b0;
          out_en_o    <= '0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_read_sequencer.sv
// Randomized bench for flash_read_sequencer against a phase-arithmetic model
// of the read sequence, with a simple array model behind out_en.
module tb_flash_read_sequencer;
  localparam int PRE = 4;
  localparam int SEN = 8;
  localparam int OE  = 2;
  localparam int TOT = PRE + SEN + OE + 2;

  logic        wb_clk_i, wb_rst_ni;
  logic        req_valid_i, req_ready_o, abort_i;
  logic [3:0]  req_sel_i, out_en_o;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [7:0]  rsp_data_o, flash_out_i, arr_data;
  logic [15:0] rd_count_o;
  logic        sen1_o, sen2_o;

  int          n_cmp, n_err;
  logic [15:0] cnt_model;

  flash_read_sequencer #(.PRE_CYC(PRE), .SEN_CYC(SEN), .OE_CYC(OE)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_sel_i   (req_sel_i),
    .abort_i     (abort_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .rd_count_o  (rd_count_o),
    .sen1_o      (sen1_o),
    .sen2_o      (sen2_o),
    .out_en_o    (out_en_o),
    .flash_out_i (flash_out_i)
  );

  // Array drives its stored word only while some output enable is on.
  assign flash_out_i = (out_en_o != 4'd0) ? arr_data : ~arr_data;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_drives(input string tag);
    chk({tag, "_drv"}, {27'd0, sen1_o, sen2_o, out_en_o}, 32'd0);
  endtask

  // One read: sel, array word, cycle index to abort at (-1 none), response stall.
  task automatic do_read(input logic [3:0] sel, input logic [7:0] data,
                         input int abort_at, input int bp);
    int total, w;
    total = (sel == 4'd0) ? 0 : TOT;
    w = 0;
    while (!req_ready_o && w < 8) begin
      @(negedge wb_clk_i);
      w++;
    end
    chk("ready_wait", req_ready_o, 1);
    arr_data    = data;
    req_valid_i = 1'b1;
    req_sel_i   = sel;
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
    req_sel_i   = 4'($urandom);
    for (int k = 0; k < total; k++) begin
      chk("sen1", sen1_o, 1);
      chk("sen2", sen2_o, (k >= PRE) ? 1 : 0);
      chk("out_en", out_en_o, (k >= PRE + SEN) ? sel : 4'd0);
      chk("busy_valid", rsp_valid_o, 0);
      chk("busy_ready", req_ready_o, 0);
      if (k == abort_at) begin
        abort_i = 1'b1;
        @(negedge wb_clk_i);
        abort_i = 1'b0;
        chk_idle_drives("abort");
        chk("abort_ready", req_ready_o, 1);
        chk("abort_valid", rsp_valid_o, 0);
        chk("abort_count", rd_count_o, cnt_model);
        return;
      end
      @(negedge wb_clk_i);
    end
    if (sel != 4'd0) cnt_model = cnt_model + 16'd1;
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_data", rsp_data_o, (sel != 4'd0) ? data : 8'd0);
    chk("rsp_err", rsp_err_o, (sel == 4'd0) ? 1 : 0);
    chk("rd_count", rd_count_o, cnt_model);
    chk_idle_drives("resp");
    // Stall the response; abort must be ignored while responding.
    for (int i = 0; i < bp; i++) begin
      abort_i = i[0];
      @(negedge wb_clk_i);
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_data", rsp_data_o, (sel != 4'd0) ? data : 8'd0);
      chk("bp_ready", req_ready_o, 0);
    end
    abort_i     = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    chk("hs_valid", rsp_valid_o, 0);
    chk("hs_ready", req_ready_o, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cnt_model = 16'd0;
    wb_rst_ni = 1'b0; req_valid_i = 1'b0; req_sel_i = 4'd0;
    abort_i = 1'b0; rsp_ready_i = 1'b0; arr_data = 8'h00;
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_data", rsp_data_o, 0);
    chk("rst_count", rd_count_o, 0);
    chk_idle_drives("rst");
    #21 wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    chk("post_rst_ready", req_ready_o, 1);

    do_read(4'b0001, 8'hA5, -1, 0);
    do_read(4'b0000, 8'h33, -1, 0);
    do_read(4'b0010, 8'h3C, -1, 20);
    do_read(4'b0100, 8'h77, PRE + 2, 0);
    do_read(4'b1000, 8'h5A, TOT - 1, 0);
    do_read(4'b0011, 8'hC3, -1, 1);

    for (int n = 0; n < 25; n++) begin
      logic [3:0] s;
      int ab;
      s  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ab = ($urandom_range(0, 3) == 0 && s != 4'd0) ? int'($urandom_range(0, TOT - 1)) : -1;
      do_read(s, 8'($urandom), ab, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of OUT.
    do begin
      @(negedge wb_clk_i);
    end while (!req_ready_o);
    arr_data = 8'h99; req_valid_i = 1'b1; req_sel_i = 4'hF;
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
    repeat (PRE + SEN + 1) @(negedge wb_clk_i);
    chk("pre_rst_oe", out_en_o, 4'hF);
    #2 wb_rst_ni = 1'b0;
    #1;
    chk_idle_drives("async_rst");
    chk("async_rst_valid", rsp_valid_o, 0);
    chk("async_rst_count", rd_count_o, 0);
    cnt_model = 16'd0;
    @(negedge wb_clk_i);
    #2 wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    chk("rel_ready", req_ready_o, 1);
    chk("rel_count", rd_count_o, 0);
    chk("rel_valid", rsp_valid_o, 0);

    // Counter wrap.
    force dut.rd_count_o = 16'hFFFF;
    #1 release dut.rd_count_o;
    #1 chk("wrap_preload", rd_count_o, 16'hFFFF);
    cnt_model = 16'hFFFF;
    do_read(4'b0101, 8'h1E, -1, 0);
    chk("wrap_zero", rd_count_o, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
